// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM; optional MULDIV path under `MDU_EN
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  input  logic        dmem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        branch_taken,
  output logic [31:0] ir,
  output logic [2:0]  ImmSel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        mdu_start,
  input  logic        mdu_done,
  output logic        illegal
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
`ifdef MDU_EN
  localparam logic [2:0] MULDIV = 3'd5;
`endif
  localparam logic [2:0] WB     = 3'd6;
  localparam logic [2:0] TRAP   = 3'd7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;
  localparam logic [31:0] NOP_INSN   = 32'h00000013;

  logic [2:0] state;
  logic [2:0] state_n;

  logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic is_load, is_store, is_opimm, is_op, is_fence;
  logic is_mext, is_legal;

`ifdef MDU_EN
  logic mdu_first;
`else
  logic unused_mdu_done;
  assign unused_mdu_done = mdu_done;
`endif

  // Opcode class flags from the held instruction word
  always_comb begin
    is_lui    = (ir[6:0] == OPC_LUI);
    is_auipc  = (ir[6:0] == OPC_AUIPC);
    is_jal    = (ir[6:0] == OPC_JAL);
    is_jalr   = (ir[6:0] == OPC_JALR);
    is_branch = (ir[6:0] == OPC_BRANCH);
    is_load   = (ir[6:0] == OPC_LOAD);
    is_store  = (ir[6:0] == OPC_STORE);
    is_opimm  = (ir[6:0] == OPC_OPIMM);
    is_op     = (ir[6:0] == OPC_OP);
    is_fence  = (ir[6:0] == OPC_FENCE);
    is_mext   = is_op && (ir[31:25] == FUNCT7_MEXT);
    is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                is_load | is_store | is_opimm | is_op | is_fence;
  end

  // Immediate format select for the immediate generator
  always_comb begin
    ImmSel = 3'd0;
    case (ir[6:0])
      OPC_LUI, OPC_AUIPC: ImmSel = 3'd3;
      OPC_JAL:            ImmSel = 3'd4;
      OPC_BRANCH:         ImmSel = 3'd2;
      OPC_STORE:          ImmSel = 3'd1;
      default:            ImmSel = 3'd0;
    endcase
  end

  // Next-state and per-state strobes; everything not driven in a state stays 0
  always_comb begin
    state_n   = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    mdu_start = 1'b0;
    case (state)
      IDLE: begin
        state_n = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_n = DECODE;
      end
      DECODE: begin
        state_n = is_legal ? EXEC : TRAP;
      end
      EXEC: begin
        if (is_load || is_store) begin
          state_n = MEM;
        end else if (is_branch) begin
          // Branches retire here: the compare result picks PC+imm or PC+4
          pc_we   = 1'b1;
          pc_sel  = {1'b0, branch_taken};
          state_n = FETCH;
        end else if (is_fence) begin
          pc_we   = 1'b1;
          state_n = FETCH;
        end else if (is_mext) begin
`ifdef MDU_EN
          state_n = MULDIV;
`else
          state_n = TRAP;
`endif
        end else begin
          state_n = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ready) begin
          if (is_store) begin
            // Stores have nothing to write back, so they retire from MEM
            pc_we   = 1'b1;
            state_n = FETCH;
          end else begin
            state_n = WB;
          end
        end
      end
`ifdef MDU_EN
      MULDIV: begin
        mdu_start = mdu_first;
        if (mdu_done) state_n = WB;
      end
`endif
      WB: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_n = FETCH;
        if (is_jal) begin
          wb_sel = 2'd2;
          pc_sel = 2'd1;
        end else if (is_jalr) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end else if (is_load) begin
          wb_sel = 2'd1;
        end else if (is_mext) begin
          wb_sel = 2'd3;
        end
      end
      TRAP: begin
        state_n = TRAP;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register and instruction capture on fetch completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= NOP_INSN;
    end else begin
      state <= state_n;
      if (state == FETCH && imem_ready) ir <= imem_rdata;
    end
  end

  // Sticky illegal flag, set on the way into TRAP and cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (state_n == TRAP) begin
      illegal <= 1'b1;
    end
  end

`ifdef MDU_EN
  // Marks the first MULDIV cycle so mdu_start is a single pulse per instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_first <= 1'b0;
    end else begin
      mdu_first <= (state != MULDIV) && (state_n == MULDIV);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl (MDU_EN aware)
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic        dmem_ready = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        branch_taken = 1'b0;
  logic [31:0] ir;
  logic [2:0]  ImmSel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        mdu_start;
  logic        mdu_done = 1'b0;
  logic        illegal;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .imem_req(imem_req),
    .dmem_ready(dmem_ready), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .branch_taken(branch_taken), .ir(ir), .ImmSel(ImmSel),
    .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rf; int wb; int pcs; int lat; int imm; int dreq; int dwe; int ms;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0, t0 = 0, rf_cnt = 0, dreq_cnt = 0, dwe_cnt = 0, ms_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic exp_t mk(int rf, int wb, int pcs, int lat, int imm, int dreq, int dwe, int ms);
    exp_t e;
    e.rf = rf; e.wb = wb; e.pcs = pcs; e.lat = lat;
    e.imm = imm; e.dreq = dreq; e.dwe = dwe; e.ms = ms;
    return e;
  endfunction

  // Monitor: per-instruction strobe tallies, scoreboard pop at each retire (pc_we)
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (imem_req && imem_ready) begin
      t0 = cyc; rf_cnt = 0; dreq_cnt = 0; dwe_cnt = 0; ms_cnt = 0;
    end
    if (rf_we)     rf_cnt++;
    if (dmem_req)  dreq_cnt++;
    if (dmem_we)   dwe_cnt++;
    if (mdu_start) ms_cnt++;
    if (pc_we) begin
      if (exp_q.size() == 0 || !rst_n) begin
        check("spurious_pc_we", {31'd0, pc_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rf_we_count", rf_cnt,      e.rf);
        check("wb_sel",      wb_sel,      e.wb);
        check("pc_sel",      pc_sel,      e.pcs);
        check("latency",     cyc - t0 + 1, e.lat);
        check("ImmSel",      ImmSel,      e.imm);
        check("dmem_req_cyc", dreq_cnt,   e.dreq);
        check("dmem_we_cyc", dwe_cnt,     e.dwe);
        check("mdu_start_n", ms_cnt,      e.ms);
      end
    end
  end

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("fetch_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Present one instruction; leaves the bench at #1 into the fetch cycle
  task automatic issue(input logic [31:0] inst, input logic bt);
    imem_rdata   = inst;
    imem_ready   = 1'b1;
    branch_taken = bt;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic run(input logic [31:0] inst, input logic bt, input int dwait,
                     input int mwait, input exp_t e);
    bit ok, done;
    int dcnt, mcnt;
    wait_fetch(ok);
    if (!ok) return;
    exp_q.push_back(e);
    issue(inst, bt);
    dcnt = 0; mcnt = -1; done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req) begin done = 1'b1; break; end
      dmem_ready = dmem_req && (dcnt >= dwait);
      if (dmem_req) dcnt++;
      if (mdu_start) mcnt = 0;
      else if (mcnt >= 0) mcnt++;
      mdu_done = (mcnt == mwait);
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    mdu_done   = 1'b0;
    if (!done) check("retire_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_outs", {imem_req, dmem_req, dmem_we, pc_we, rf_we, mdu_start,
                       illegal, ImmSel, pc_sel, wb_sel}, 32'd0);
    check("rst_ir", ir, 32'h00000013);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("idle_after_rst", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    check("fetch_after_idle", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic run_trap(input logic [31:0] inst, input string tag);
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    issue(inst, 1'b0);
    for (int i = 0; i < 4 && !illegal; i++) begin @(posedge clk); #1; end
    for (int i = 0; i < 10; i++) begin
      check(tag, {illegal, imem_req, pc_we, rf_we, dmem_req, mdu_start}, 6'b100000);
      @(posedge clk); #1;
    end
    do_reset();
    check("illegal_cleared", {31'd0, illegal}, 32'd0);
  endtask

  // Fetch inst, advance n cycles past DECODE entry, then pull reset
  task automatic abort(input logic [31:0] inst, input int n, input logic dreq_before);
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    issue(inst, 1'b0);
    repeat (n) begin @(posedge clk); #1; end
    check("pre_abort_dmem_req", {31'd0, dmem_req}, {31'd0, dreq_before});
    rst_n = 1'b0;
    #1;
    check("abort_strobes", {pc_we, rf_we, dmem_req, imem_req}, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    check("abort_hold", {pc_we, rf_we, dmem_req, illegal}, 4'b0000);
    do_reset();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    run(32'h00500093, 1'b0, 0, 0, mk(1, 0, 0, 4, 0, 0, 0, 0)); // addi
    run(32'h00208463, 1'b1, 0, 0, mk(0, 0, 1, 3, 2, 0, 0, 0)); // beq taken
    run(32'h00208463, 1'b0, 0, 0, mk(0, 0, 0, 3, 2, 0, 0, 0)); // beq not taken
    run(32'h0020a223, 1'b0, 3, 0, mk(0, 0, 0, 7, 1, 4, 4, 0)); // sw, 3 wait
    run(32'h0020a223, 1'b0, 0, 0, mk(0, 0, 0, 4, 1, 1, 1, 0)); // sw, zero wait
    run(32'h0000a103, 1'b0, 0, 0, mk(1, 1, 0, 5, 0, 1, 0, 0)); // lw
    run(32'h0000a103, 1'b0, 2, 0, mk(1, 1, 0, 7, 0, 3, 0, 0)); // lw, 2 wait
    run(32'h123450b7, 1'b0, 0, 0, mk(1, 0, 0, 4, 3, 0, 0, 0)); // lui
    run(32'h00001097, 1'b0, 0, 0, mk(1, 0, 0, 4, 3, 0, 0, 0)); // auipc
    run(32'h008000ef, 1'b0, 0, 0, mk(1, 2, 1, 4, 4, 0, 0, 0)); // jal
    run(32'h000080e7, 1'b0, 0, 0, mk(1, 2, 2, 4, 0, 0, 0, 0)); // jalr
    run(32'h0ff0000f, 1'b0, 0, 0, mk(0, 0, 0, 3, 0, 0, 0, 0)); // fence
    run(32'h40208133, 1'b1, 0, 0, mk(1, 0, 0, 4, 0, 0, 0, 0)); // sub
`ifdef MDU_EN
    run(32'h022081b3, 1'b0, 0, 5, mk(1, 3, 0, 10, 0, 0, 0, 1)); // mul, done +5
    run(32'h022081b3, 1'b0, 0, 0, mk(1, 3, 0, 5, 0, 0, 0, 1));  // mul, done at entry
`else
    run_trap(32'h022081b3, "mul_trap");
`endif
    abort(32'h008000ef, 1, 1'b0);   // jal, reset in EXEC
    abort(32'h0000a103, 2, 1'b1);   // lw, reset in MEM with dmem_req high
    run(32'h00500093, 1'b0, 0, 0, mk(1, 0, 0, 4, 0, 0, 0, 0)); // recovers after abort
    run_trap(32'hffffffff, "trap_hold");
    run(32'h00500093, 1'b0, 0, 0, mk(1, 0, 0, 4, 0, 0, 0, 0)); // recovers after trap

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 imem_rdata  input  32  fetched instruction word.
REQ-005 imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
REQ-006 imem_req  output  1  fetch request; held until imem_ready.
REQ-007 dmem_ready  input  1  data access complete.
REQ-008 dmem_req  output  1  data access request; held until dmem_ready.
REQ-009 dmem_we  output  1  data access is a store.
REQ-010 branch_taken  input  1  ALU branch-compare result, valid in EXEC.
REQ-011 ir  output  32  instruction register; feeds the immediate generator's inst input.
REQ-012 ImmSel  output  3  immediate format: I=0, S=1, B=2, U=3, J=4.
REQ-013 pc_we  output  1  PC update strobe.
REQ-014 pc_sel  output  2  next-PC source: 0=PC+4, 1=PC+imm, 2=ALU result (JALR).
REQ-015 rf_we  output  1  register-file write strobe.
REQ-016 wb_sel  output  2  writeback source: 0=ALU, 1=load data, 2=PC+4, 3=MDU.
REQ-017 mdu_start  output  1  one-cycle MDU start pulse (MDU_EN only; else tied 0).
REQ-018 mdu_done  input  1  MDU result valid (ignored without MDU_EN).
REQ-019 illegal  output  1  sticky illegal-instruction flag.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXEC, MEM, MULDIV, WB, TRAP; one state is active per cycle.
REQ-021 IDLE SHALL go to FETCH on the first clock after reset release.
REQ-022 FETCH: imem_req=1; on imem_ready, ir<=imem_rdata and go to DECODE; without imem_ready, stay in FETCH.
REQ-023 ImmSel SHALL be decoded combinationally from ir[6:0] as follows.
  - LUI 0110111 and AUIPC 0010111 -> U.
  - JAL 1101111 -> J.
  - BRANCH 1100011 -> B.
  - STORE 0100011 -> S.
  - All other opcodes -> I.
REQ-024 DECODE: an unsupported opcode SHALL go to TRAP; legal opcodes are LUI, AUIPC, JAL, JALR 1100111, BRANCH, LOAD 0000011, STORE, OP-IMM 0010011, OP 0110011 and FENCE 0001111. Otherwise go to EXEC.
REQ-025 EXEC routing:
  - LOAD/STORE -> MEM.
  - BRANCH -> FETCH with pc_we=1 and pc_sel=branch_taken?1:0.
  - FENCE -> FETCH with pc_we=1 and pc_sel=0.
  - OP with funct7=0000001 -> MULDIV (MDU_EN) or TRAP (no MDU_EN).
  - All others -> WB.
REQ-026 MEM: dmem_req=1 and dmem_we=(STORE); hold until dmem_ready. A store then goes to FETCH with pc_we=1 and pc_sel=0; a load goes to WB.
REQ-027 MULDIV: mdu_start=1 only in the entry cycle; stay until mdu_done, then go to WB. mdu_done asserted in the entry cycle SHALL be accepted.
REQ-028 WB lasts one cycle with rf_we=1 and pc_we=1, then goes to FETCH. Source selects per instruction:
  - JAL: wb_sel=2, pc_sel=1.
  - JALR: wb_sel=2, pc_sel=2.
  - LOAD: wb_sel=1, pc_sel=0.
  - MDU: wb_sel=3, pc_sel=0.
  - Others: wb_sel=0, pc_sel=0.
REQ-029 TRAP: illegal=1; all strobes 0; stay in TRAP until reset.
REQ-030 Each instruction SHALL assert pc_we exactly once and rf_we at most once. Outputs not listed for a state SHALL be 0.
REQ-031 Minimum latencies with zero-wait memory, counted from imem_ready:
  - ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
  - BRANCH, FENCE: 3 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.

Reset
REQ-032 While rst_n=0, the block SHALL hold the following values.
  - state=IDLE.
  - ir=32'h00000013 (NOP), so ImmSel=0.
  - illegal=0.
  - All strobes 0 and all selects 0.
REQ-033 Reset asserted mid-instruction (including MEM with dmem_req=1) SHALL abort immediately, with no pc_we or rf_we pulse.

Configuration
REQ-034 Macro MDU_EN. When defined, funct7=0000001 OP instructions use the MULDIV path. When undefined, they go to TRAP, mdu_start is constant 0, mdu_done is unused, and MULDIV is absent.

Verification
REQ-035 Reset, then imem_rdata=32'h00500093 (addi x1,x0,5) with imem_ready=1 -> FETCH, DECODE, EXEC, WB; in WB rf_we=1, wb_sel=0, pc_we=1, pc_sel=0; ImmSel=0.
REQ-036 Branch 32'h00208463 (beq): branch_taken=1 -> pc_we=1, pc_sel=1 in EXEC, rf_we never 1, ImmSel=2. Repeat with branch_taken=0 -> pc_sel=0.
REQ-037 Store 32'h0020a223 with dmem_ready low for 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, ImmSel=1, then pc_we=1 and rf_we never 1.
REQ-038 Instruction 32'hFFFFFFFF -> TRAP, illegal=1 persists for 10 cycles, imem_req=0; rst_n pulse -> illegal=0, state IDLE.
REQ-039 mul 32'h022081b3 with MDU_EN and mdu_done after 5 cycles -> a single mdu_start pulse, then WB with wb_sel=3; without MDU_EN -> illegal=1.
REQ-040 jal 32'h008000ef -> ImmSel=4; WB with wb_sel=2, pc_sel=1, rf_we=1. Assert rst_n=0 during EXEC -> no WB strobes appear.
